// File: rtl/alu_pkg.sv
// Opcode map, FSM state encoding and decode helpers shared by the
// iterative ALU and its multiply/divide datapath.
package alu_pkg;

    localparam logic [4:0] OP_ADD    = 5'b00000;
    localparam logic [4:0] OP_SUB    = 5'b00001;
    localparam logic [4:0] OP_SLT    = 5'b00010;
    localparam logic [4:0] OP_SLTU   = 5'b00011;
    localparam logic [4:0] OP_XOR    = 5'b00100;
    localparam logic [4:0] OP_SRL    = 5'b00101;
    localparam logic [4:0] OP_SRA    = 5'b00110;
    localparam logic [4:0] OP_AND    = 5'b00111;
    localparam logic [4:0] OP_LUI    = 5'b01000;
    localparam logic [4:0] OP_OR     = 5'b01001;
    localparam logic [4:0] OP_SLL    = 5'b01100;
    localparam logic [4:0] OP_MUL    = 5'b10000;
    localparam logic [4:0] OP_MULH   = 5'b10001;
    localparam logic [4:0] OP_MULHSU = 5'b10010;
    localparam logic [4:0] OP_MULHU  = 5'b10011;
    localparam logic [4:0] OP_DIV    = 5'b10100;
    localparam logic [4:0] OP_DIVU   = 5'b10101;
    localparam logic [4:0] OP_REM    = 5'b10110;
    localparam logic [4:0] OP_REMU   = 5'b10111;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIX} state_e;

    function automatic logic is_muldiv(input logic [4:0] op);
        return op[4:3] == 2'b10;
    endfunction

    function automatic logic is_div(input logic [4:0] op);
        return is_muldiv(op) && op[2];
    endfunction

    // Operand A is treated as two's complement for these ops.
    function automatic logic is_signed_a(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
               (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_signed_b(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Radix-2 unsigned multiply / restoring divide on operand magnitudes.
// The first step is taken on the load edge so the RUN phase is WIDTH-1 cycles.
module muldiv_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic             step_i,
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] a_mag_i,
    input  logic [WIDTH-1:0] b_mag_i,
    output logic             last_o,
    output logic [WIDTH-1:0] acc_o,
    output logic [WIDTH-1:0] mq_o
);

    logic [WIDTH-1:0] acc_q, mq_q, b_q;
    logic             is_div_q;
    logic [CNT_W-1:0] cnt_q;

    logic [WIDTH-1:0] acc_in, mq_in, d;
    logic             div_sel;
    logic [WIDTH:0]   sum, rem_sh, diff;
    logic             ge;
    logic [WIDTH-1:0] acc_nxt, mq_nxt;

    always_comb begin
        acc_in  = load_i ? '0 : acc_q;
        mq_in   = load_i ? a_mag_i : mq_q;
        d       = load_i ? b_mag_i : b_q;
        div_sel = load_i ? is_div_i : is_div_q;

        // multiply: {acc,mq} holds partial product with multiplier in the low half
        sum     = {1'b0, acc_in} + (mq_in[0] ? {1'b0, d} : '0);
        // divide: {acc,mq} holds remainder with dividend/quotient in the low half
        rem_sh  = {acc_in, mq_in[WIDTH-1]};
        ge      = rem_sh >= {1'b0, d};
        diff    = rem_sh - {1'b0, d};

        if (div_sel) begin
            acc_nxt = ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
            mq_nxt  = {mq_in[WIDTH-2:0], ge};
        end else begin
            acc_nxt = sum[WIDTH:1];
            mq_nxt  = {sum[0], mq_in[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            acc_q    <= '0;
            mq_q     <= '0;
            b_q      <= '0;
            is_div_q <= 1'b0;
            cnt_q    <= '0;
        end else if (load_i) begin
            acc_q    <= acc_nxt;
            mq_q     <= mq_nxt;
            b_q      <= b_mag_i;
            is_div_q <= is_div_i;
            cnt_q    <= CNT_W'(1);
        end else if (step_i) begin
            acc_q    <= acc_nxt;
            mq_q     <= mq_nxt;
            cnt_q    <= cnt_q + CNT_W'(1);
        end
    end

    assign last_o = (cnt_q == CNT_W'(WIDTH - 1));
    assign acc_o  = acc_q;
    assign mq_o   = mq_q;

endmodule

// File: rtl/alu_iter_muldiv.sv
// EX-stage ALU: single-cycle RV32I ops plus iterative RV32M mul/div behind
// a start/done handshake.
module alu_iter_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH),
    parameter int CNT_W   = $clog2(WIDTH) + 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [4:0]       ALU_Operation_i,
    input  logic [WIDTH-1:0] A_i,
    input  logic [WIDTH-1:0] B_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] ALU_Result_o,
    output logic             Zero_o
);

    localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

    state_e state_q, state_n;
    logic [4:0] op_q;
    logic       neg_q, neg_rem_q;

    logic             accept, a_neg, b_neg, div0, ovf, fast, iter_start, last;
    logic [WIDTH-1:0] a_mag, b_mag, base_res, fast_res, fix_res, acc, mq;
    logic [SHAMT_W-1:0]   shamt;
    logic [2*WIDTH-1:0]   prod;

    assign busy_o = (state_q != ST_IDLE);
    assign accept = start_i && (state_q == ST_IDLE);
    assign shamt  = B_i[SHAMT_W-1:0];

    always_comb begin
        a_neg = is_signed_a(ALU_Operation_i) && A_i[WIDTH-1];
        b_neg = is_signed_b(ALU_Operation_i) && B_i[WIDTH-1];
        a_mag = a_neg ? -A_i : A_i;
        b_mag = b_neg ? -B_i : B_i;

        // divide-by-zero and signed overflow bypass the iterative datapath
        div0 = is_div(ALU_Operation_i) && (B_i == '0);
        ovf  = is_div(ALU_Operation_i) && is_signed_a(ALU_Operation_i) &&
               (A_i == MIN_INT) && (B_i == '1);
        fast = div0 || ovf;
        if (div0) fast_res = ALU_Operation_i[1] ? A_i : '1;
        else      fast_res = ALU_Operation_i[1] ? '0 : A_i;

        iter_start = accept && is_muldiv(ALU_Operation_i) && !fast;
    end

    always_comb begin
        base_res = '0;
        case (ALU_Operation_i)
            OP_ADD:  base_res = A_i + B_i;
            OP_SUB:  base_res = A_i - B_i;
            OP_SLT:  base_res = WIDTH'($signed(A_i) < $signed(B_i));
            OP_SLTU: base_res = WIDTH'(A_i < B_i);
            OP_XOR:  base_res = A_i ^ B_i;
            OP_SRL:  base_res = A_i >> shamt;
            OP_SRA:  base_res = WIDTH'($signed(A_i) >>> shamt);
            OP_AND:  base_res = A_i & B_i;
            OP_LUI:  base_res = B_i;
            OP_OR:   base_res = A_i | B_i;
            OP_SLL:  base_res = A_i << shamt;
            default: base_res = '0;
        endcase
    end

    always_comb begin
        prod = neg_q ? -{acc, mq} : {acc, mq};
        if (op_q[2]) begin
            if (op_q[1]) fix_res = neg_rem_q ? -acc : acc;
            else         fix_res = neg_q ? -mq : mq;
        end else begin
            fix_res = (op_q[1:0] == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
        end
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            ST_IDLE: if (iter_start) state_n = ST_RUN;
            ST_RUN:  if (last) state_n = ST_FIX;
            ST_FIX:  state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            op_q         <= '0;
            neg_q        <= 1'b0;
            neg_rem_q    <= 1'b0;
            done_o       <= 1'b0;
            ALU_Result_o <= '0;
            Zero_o       <= 1'b1;
        end else begin
            state_q <= state_n;
            done_o  <= 1'b0;
            if (iter_start) begin
                op_q      <= ALU_Operation_i;
                neg_q     <= a_neg ^ b_neg;
                neg_rem_q <= a_neg;
            end else if (accept) begin
                ALU_Result_o <= fast ? fast_res : base_res;
                Zero_o       <= fast ? (fast_res == '0) : (base_res == '0);
                done_o       <= 1'b1;
            end else if (state_q == ST_FIX) begin
                ALU_Result_o <= fix_res;
                Zero_o       <= (fix_res == '0);
                done_o       <= 1'b1;
            end
        end
    end

    muldiv_iter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_muldiv (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .load_i   (iter_start),
        .step_i   (state_q == ST_RUN),
        .is_div_i (is_div(ALU_Operation_i)),
        .a_mag_i  (a_mag),
        .b_mag_i  (b_mag),
        .last_o   (last),
        .acc_o    (acc),
        .mq_o     (mq)
    );

endmodule

// File: tb/tb_alu_iter_muldiv.sv
// Directed-vector bench for alu_iter_muldiv at WIDTH=32.
module tb_alu_iter_muldiv;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        start_i = 1'b0;
    logic [4:0]  ALU_Operation_i = '0;
    logic [31:0] A_i = '0, B_i = '0;
    logic        busy_o, done_o, Zero_o;
    logic [31:0] ALU_Result_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    alu_iter_muldiv #(.WIDTH(32)) dut (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .start_i         (start_i),
        .ALU_Operation_i (ALU_Operation_i),
        .A_i             (A_i),
        .B_i             (B_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .ALU_Result_o    (ALU_Result_o),
        .Zero_o          (Zero_o)
    );

    always #5 clk_i = ~clk_i;

    // Issues one op from an idle point (#1 after an edge) and waits for done.
    // lat counts edges from the accept edge (inclusive) until done is seen.
    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output logic z, output int lat);
        ALU_Operation_i = op; A_i = a; B_i = b; start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0; A_i = $urandom; B_i = $urandom;
        lat = 1;
        while (!done_o && lat < 200) begin
            @(posedge clk_i); #1;
            lat++;
        end
        r = ALU_Result_o; z = Zero_o;
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || ALU_Result_o !== 32'h0 || Zero_o !== 1'b1) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b res=%h zero=%b, want 0 0 00000000 1",
                     busy_o, done_o, ALU_Result_o, Zero_o);
        end
        reset_i = 1'b0;
        @(posedge clk_i); #1;
    endtask

    task automatic test_base();
        vec_t v[12];
        logic [31:0] r; logic z; int lat;
        v = '{'{5'b00000, 32'd5,        32'hFFFFFFFB, 32'h00000000},
              '{5'b00001, 32'd3,        32'd5,        32'hFFFFFFFE},
              '{5'b00010, 32'hFFFFFFFF, 32'd1,        32'h00000001},
              '{5'b00011, 32'hFFFFFFFF, 32'd1,        32'h00000000},
              '{5'b00100, 32'h0000F0F0, 32'h0000FF00, 32'h00000FF0},
              '{5'b00101, 32'h80000000, 32'd4,        32'h08000000},
              '{5'b00110, 32'h80000000, 32'd4,        32'hF8000000},
              '{5'b00111, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000},
              '{5'b01000, 32'hDEADBEEF, 32'h12345000, 32'h12345000},
              '{5'b01001, 32'h000000F0, 32'h00000F00, 32'h00000FF0},
              '{5'b01100, 32'h00000001, 32'h00000023, 32'h00000008},
              '{5'b11111, 32'h12345678, 32'h9ABCDEF0, 32'h00000000}};
        for (int i = 0; i < 12; i++) begin
            run_op(v[i].op, v[i].a, v[i].b, r, z, lat);
            checks++;
            if (r !== v[i].exp || lat !== 1 || z !== (v[i].exp == 32'h0)) begin
                errors++;
                $display("FAIL base op=%b: res=%h zero=%b lat=%0d, want res=%h zero=%b lat=1",
                         v[i].op, r, z, lat, v[i].exp, (v[i].exp == 32'h0));
            end
        end
        @(posedge clk_i); #1;
        checks++;
        if (done_o !== 1'b0 || ALU_Result_o !== 32'h0) begin
            errors++;
            $display("FAIL done_pulse: done=%b res=%h, want done=0 res held 00000000",
                     done_o, ALU_Result_o);
        end
    endtask

    task automatic test_mul();
        vec_t v[5];
        logic [31:0] r; logic z; int lat;
        v = '{'{5'b10000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001},
              '{5'b10001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000},
              '{5'b10011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE},
              '{5'b10010, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF},
              '{5'b10000, 32'd12345,    32'd1000,     32'd12345000}};
        for (int i = 0; i < 5; i++) begin
            run_op(v[i].op, v[i].a, v[i].b, r, z, lat);
            checks++;
            if (r !== v[i].exp || lat !== 33 || z !== (v[i].exp == 32'h0)) begin
                errors++;
                $display("FAIL mul op=%b: res=%h zero=%b lat=%0d, want res=%h lat=33",
                         v[i].op, r, z, lat, v[i].exp);
            end
        end
    endtask

    task automatic test_div();
        vec_t v[6];
        logic [31:0] r; logic z; int lat;
        v = '{'{5'b10100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD},
              '{5'b10110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF},
              '{5'b10101, 32'd100,      32'd7,        32'd14},
              '{5'b10111, 32'd100,      32'd7,        32'd2},
              '{5'b10100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD},
              '{5'b10110, 32'd7,        32'hFFFFFFFE, 32'd1}};
        for (int i = 0; i < 6; i++) begin
            run_op(v[i].op, v[i].a, v[i].b, r, z, lat);
            checks++;
            if (r !== v[i].exp || lat !== 33) begin
                errors++;
                $display("FAIL div op=%b: res=%h lat=%0d, want res=%h lat=33",
                         v[i].op, r, lat, v[i].exp);
            end
        end
    endtask

    task automatic test_fastpath();
        vec_t v[6];
        logic [31:0] r; logic z; int lat;
        v = '{'{5'b10101, 32'd10,       32'd0,        32'hFFFFFFFF},
              '{5'b10111, 32'd10,       32'd0,        32'd10},
              '{5'b10100, 32'd5,        32'd0,        32'hFFFFFFFF},
              '{5'b10110, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB},
              '{5'b10100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000},
              '{5'b10110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000}};
        for (int i = 0; i < 6; i++) begin
            run_op(v[i].op, v[i].a, v[i].b, r, z, lat);
            checks++;
            if (r !== v[i].exp || lat !== 1 || z !== (v[i].exp == 32'h0)) begin
                errors++;
                $display("FAIL fastpath op=%b: res=%h zero=%b lat=%0d, want res=%h lat=1",
                         v[i].op, r, z, lat, v[i].exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic bad;
        ALU_Operation_i = 5'b10000; A_i = 32'd7; B_i = 32'd6; start_i = 1'b1;
        @(posedge clk_i); #1;
        // keep requesting with a different op/operands while the MUL runs
        ALU_Operation_i = 5'b10011; A_i = 32'hFFFFFFFF; B_i = 32'hFFFFFFFF;
        lat = 1; bad = 1'b0;
        while (!done_o && lat < 200) begin
            if (!busy_o) bad = 1'b1;
            @(posedge clk_i); #1;
            lat++;
        end
        checks++;
        if (ALU_Result_o !== 32'd42 || lat !== 33 || bad !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first: res=%h lat=%0d busy_drop=%b busy=%b, want 0000002a 33 0 0",
                     ALU_Result_o, lat, bad, busy_o);
        end
        @(posedge clk_i); #1;
        start_i = 1'b0;
        lat = 1;
        checks++;
        if (busy_o !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept: busy=%b, want 1", busy_o);
        end
        while (!done_o && lat < 200) begin
            @(posedge clk_i); #1;
            lat++;
        end
        checks++;
        if (ALU_Result_o !== 32'hFFFFFFFE || lat !== 33) begin
            errors++;
            $display("FAIL b2b_second: res=%h lat=%0d, want fffffffe 33", ALU_Result_o, lat);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] r; logic z; int lat;
        ALU_Operation_i = 5'b10101; A_i = 32'd100; B_i = 32'd7; start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        repeat (10) @(posedge clk_i);
        #1;
        checks++;
        if (busy_o !== 1'b1 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL mid_busy: busy=%b done=%b, want 1 0", busy_o, done_o);
        end
        reset_i = 1'b1;
        @(posedge clk_i); #1;
        reset_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || ALU_Result_o !== 32'h0 || Zero_o !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset: busy=%b done=%b res=%h zero=%b, want 0 0 00000000 1",
                     busy_o, done_o, ALU_Result_o, Zero_o);
        end
        run_op(5'b00000, 32'd3, 32'd4, r, z, lat);
        checks++;
        if (r !== 32'd7 || z !== 1'b0 || lat !== 1) begin
            errors++;
            $display("FAIL post_reset_add: res=%h zero=%b lat=%0d, want 00000007 0 1", r, z, lat);
        end
    endtask

    initial begin
        test_reset();
        test_base();
        test_mul();
        test_div();
        test_fastpath();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
